// File: rtl/mcycle_scheduler.sv
// Issue/hazard/writeback scheduler for a single multi-cycle MUL/DIV unit.
// Optional watchdog on the RUN phase is enabled with `define MCS_TIMEOUT_EN.
module mcycle_scheduler #(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             issue_valid,
  input  logic             issue_op,
  input  logic [3:0]       issue_rd,
  input  logic [3:0]       d_ra1,
  input  logic [3:0]       d_ra2,
  input  logic [3:0]       d_rd,
  input  logic             d_wr,
  input  logic             flush,
  input  logic             mc_busy,
  input  logic [WIDTH-1:0] mc_result,
  input  logic             wb_free,
  output logic             mc_start,
  output logic             mc_op,
  output logic             stall_fd,
  output logic             inj_we,
  output logic [3:0]       inj_rd,
  output logic [WIDTH-1:0] inj_data,
  output logic             pend_valid,
  output logic [3:0]       pend_rd,
  output logic             timeout_err
);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic             first_q, first_d;
  logic [3:0]       pend_rd_q, pend_rd_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             res_valid;
  logic             timeout_fire;
  logic             hazard;

  // The unit's busy flag is not yet meaningful in the cycle right after start.
  assign res_valid = (state_q == StRun) && !first_q && !mc_busy;

  assign pend_valid = (state_q != StIdle);
  assign pend_rd    = pend_valid ? pend_rd_q : 4'd0;
  assign hazard     = (d_ra1 == pend_rd_q) || (d_ra2 == pend_rd_q) ||
                      (d_wr && (d_rd == pend_rd_q));
  assign stall_fd   = pend_valid && (issue_valid || hazard);

  always_comb begin
    state_d   = state_q;
    first_d   = 1'b0;
    pend_rd_d = pend_rd_q;
    hold_d    = hold_q;
    mc_start  = 1'b0;
    mc_op     = 1'b0;
    inj_we    = 1'b0;
    inj_rd    = 4'd0;
    inj_data  = '0;
    case (state_q)
      StIdle: begin
        if (issue_valid && !flush) begin
          mc_start  = 1'b1;
          mc_op     = issue_op;
          pend_rd_d = issue_rd;
          first_d   = 1'b1;
          state_d   = StRun;
        end
      end
      StRun: begin
        if (timeout_fire) begin
          state_d = StIdle;
        end else if (res_valid) begin
          if (wb_free) begin
            inj_we   = 1'b1;
            inj_rd   = pend_rd_q;
            inj_data = mc_result;
            state_d  = StIdle;
          end else begin
            hold_d  = mc_result;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (wb_free) begin
          inj_we   = 1'b1;
          inj_rd   = pend_rd_q;
          inj_data = hold_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A reset cycle must never launch or retire an operation.
    if (!Reset) begin
      mc_start = 1'b0;
      mc_op    = 1'b0;
      inj_we   = 1'b0;
      inj_rd   = 4'd0;
      inj_data = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      state_q   <= StIdle;
      first_q   <= 1'b0;
      pend_rd_q <= 4'd0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      first_q   <= first_d;
      pend_rd_q <= pend_rd_d;
      hold_q    <= hold_d;
    end
  end

`ifdef MCS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] wdog_q, wdog_d;
  logic            timeout_err_q, timeout_err_d;

  // Counter holds (RUN cycles elapsed - 1), so the limit trips on the last allowed cycle.
  assign timeout_fire = (state_q == StRun) && (wdog_q == CntW'(TIMEOUT_CYCLES - 1));
  assign timeout_err  = timeout_err_q;

  always_comb begin
    wdog_d        = wdog_q;
    timeout_err_d = timeout_err_q | timeout_fire;
    if (mc_start) begin
      wdog_d = '0;
    end else if (state_q == StRun) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!Reset) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end
`else
  logic unused_timeout_cycles;

  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout_fire          = 1'b0;
  assign timeout_err           = 1'b0;
`endif

endmodule

// File: tb/tb_mcycle_scheduler.sv
// Self-checking bench for mcycle_scheduler: directed scenarios plus randomized
// transactions checked against a transaction-level timeline model.
module tb_mcycle_scheduler;

  logic        CLK;
  logic        Reset;
  logic        issue_valid;
  logic        issue_op;
  logic [3:0]  issue_rd;
  logic [3:0]  d_ra1;
  logic [3:0]  d_ra2;
  logic [3:0]  d_rd;
  logic        d_wr;
  logic        flush;
  logic        mc_busy;
  logic [31:0] mc_result;
  logic        wb_free;
  logic        mc_start;
  logic        mc_op;
  logic        stall_fd;
  logic        inj_we;
  logic [3:0]  inj_rd;
  logic [31:0] inj_data;
  logic        pend_valid;
  logic [3:0]  pend_rd;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  bit exp_to = 1'b0;

  mcycle_scheduler #(
    .WIDTH         (32),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK        (CLK),
    .Reset      (Reset),
    .issue_valid(issue_valid),
    .issue_op   (issue_op),
    .issue_rd   (issue_rd),
    .d_ra1      (d_ra1),
    .d_ra2      (d_ra2),
    .d_rd       (d_rd),
    .d_wr       (d_wr),
    .flush      (flush),
    .mc_busy    (mc_busy),
    .mc_result  (mc_result),
    .wb_free    (wb_free),
    .mc_start   (mc_start),
    .mc_op      (mc_op),
    .stall_fd   (stall_fd),
    .inj_we     (inj_we),
    .inj_rd     (inj_rd),
    .inj_data   (inj_data),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd),
    .timeout_err(timeout_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already driven; check outputs mid-cycle, then advance.
  task automatic step(input bit e_start, input bit e_op, input bit e_pv,
                      input logic [3:0] e_prd, input bit e_inj, input logic [31:0] e_data);
    bit haz;
    haz = (d_ra1 == e_prd) || (d_ra2 == e_prd) || (d_wr && (d_rd == e_prd));
    #4;
    chk("mc_start", 64'(mc_start), 64'(e_start));
    chk("mc_op", 64'(mc_op), 64'(e_op));
    chk("stall_fd", 64'(stall_fd), 64'(e_pv && (issue_valid || haz)));
    chk("pend_valid", 64'(pend_valid), 64'(e_pv));
    chk("pend_rd", 64'(pend_rd), e_pv ? 64'(e_prd) : 64'd0);
    chk("inj_we", 64'(inj_we), 64'(e_inj));
    chk("inj_rd", 64'(inj_rd), e_inj ? 64'(e_prd) : 64'd0);
    chk("inj_data", 64'(inj_data), e_inj ? 64'(e_data) : 64'd0);
    chk("timeout_err", 64'(timeout_err), 64'(exp_to));
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_d();
    d_ra1 = 4'($urandom_range(0, 3));
    d_ra2 = 4'($urandom_range(0, 3));
    d_rd  = 4'($urandom_range(0, 3));
    d_wr  = 1'($urandom);
  endtask

  // One operation: issue, 1 ignored-busy cycle, lat busy cycles, then result
  // with wait_c cycles of wb_free=0 before the slot opens.
  task automatic txn(input logic op, input logic [3:0] rd, input int lat, input int wait_c,
                     input logic [31:0] res, input bit noise, input bit bg_issue);
    issue_valid = 1'b1;
    flush       = 1'b0;
    issue_op    = op;
    issue_rd    = rd;
    mc_busy     = 1'b0;
    wb_free     = 1'($urandom);
    if (noise) rand_d();
    step(1'b1, op, 1'b0, 4'd0, 1'b0, 32'd0);
    for (int k = 1; k <= lat + 1; k++) begin
      issue_valid = noise ? 1'($urandom) : bg_issue;
      flush       = noise ? 1'($urandom) : 1'b0;
      issue_op    = 1'($urandom);
      issue_rd    = 4'($urandom);
      mc_busy     = (k == 1 && noise) ? 1'($urandom) : 1'b1;
      wb_free     = 1'($urandom);
      mc_result   = $urandom;
      if (noise) rand_d();
      step(1'b0, 1'b0, 1'b1, rd, 1'b0, 32'd0);
    end
    for (int k = 0; k <= wait_c; k++) begin
      issue_valid = noise ? 1'($urandom) : bg_issue;
      flush       = noise ? 1'($urandom) : 1'b0;
      mc_busy     = 1'b0;
      wb_free     = (k == wait_c);
      mc_result   = (k == 0) ? res : $urandom;
      if (noise) rand_d();
      step(1'b0, 1'b0, 1'b1, rd, k == wait_c, res);
    end
    issue_valid = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    int g;
    Reset       = 1'b0;
    issue_valid = 1'b0;
    issue_op    = 1'b0;
    issue_rd    = 4'd0;
    d_ra1       = 4'd0;
    d_ra2       = 4'd0;
    d_rd        = 4'd0;
    d_wr        = 1'b0;
    flush       = 1'b0;
    mc_busy     = 1'b0;
    mc_result   = 32'd0;
    wb_free     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    Reset = 1'b1;
    d_ra1 = 4'd1;
    d_ra2 = 4'd2;
    d_rd  = 4'd3;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);

    // MUL rd=4: busy 8 cycles, then immediate writeback.
    txn(1'b0, 4'd4, 7, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);

    // DIV rd=4 held 3 cycles; D reads r4 so the front end stalls throughout.
    d_ra1 = 4'd5;
    d_ra2 = 4'd4;
    d_wr  = 1'b0;
    txn(1'b1, 4'd4, 2, 3, 32'h1234_5678, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);

    // No dependency on r4: no stall.
    d_ra2 = 4'd6;
    txn(1'b0, 4'd4, 1, 1, 32'h0000_00A5, 1'b0, 1'b0);

    // Flushed issue is ignored; a second issue while busy stalls.
    issue_valid = 1'b1;
    flush       = 1'b1;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    issue_valid = 1'b0;
    flush       = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    txn(1'b1, 4'd9, 3, 2, 32'hCAFE_0001, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);

    // Reset during the third RUN cycle discards the operation.
    issue_valid = 1'b1;
    issue_op    = 1'b1;
    issue_rd    = 4'd6;
    step(1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 32'd0);
    issue_valid = 1'b0;
    mc_busy     = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 4'd6, 1'b0, 32'd0);
    Reset = 1'b0;
    @(posedge CLK);
    #1;
    Reset   = 1'b1;
    mc_busy = 1'b0;
    wb_free = 1'b1;
    repeat (4) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);

`ifdef MCS_TIMEOUT_EN
    // Busy stuck high: watchdog abandons after 16 RUN cycles.
    issue_valid = 1'b1;
    issue_op    = 1'b0;
    issue_rd    = 4'd7;
    mc_busy     = 1'b0;
    step(1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    issue_valid = 1'b0;
    mc_busy     = 1'b1;
    repeat (16) step(1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 32'd0);
    exp_to = 1'b1;
    repeat (3) step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
    mc_busy = 1'b0;
    Reset   = 1'b0;
    @(posedge CLK);
    #1;
    Reset  = 1'b1;
    exp_to = 1'b0;
    step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
`endif

    // Randomized transactions with noisy D-stage and issue traffic.
    for (int t = 0; t < 60; t++) begin
      g = $urandom_range(0, 2);
      for (int i = 0; i < g; i++) begin
        issue_valid = 1'($urandom);
        flush       = issue_valid ? 1'b1 : 1'($urandom);
        issue_op    = 1'($urandom);
        issue_rd    = 4'($urandom);
        mc_busy     = 1'b0;
        wb_free     = 1'($urandom);
        mc_result   = $urandom;
        rand_d();
        step(1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 32'd0);
      end
      txn(1'($urandom), 4'($urandom_range(0, 3)), $urandom_range(0, 6),
          $urandom_range(0, 3), $urandom, 1'b1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
